// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequenced by a three-state FSM
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic s1, c1, s, c2, carry_next;

   // One full-adder cell from two half-adders; the only arithmetic in the block.
   always_comb begin
      s1         = a_sh[0] ^ b_sh[0];
      c1         = a_sh[0] & b_sh[0];
      s          = s1 ^ carry;
      c2         = s1 & carry;
      carry_next = c1 | c2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               res   <= {s, res[WIDTH-1:1]};
               carry <= carry_next;
               cnt   <= cnt + CW'(1);
               // Publish only on the final bit so sum/cout hold the old result meanwhile.
               if (cnt == CW'(WIDTH - 1)) begin
                  sum   <= {s, res[WIDTH-1:1]};
                  cout  <= carry_next;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int total = 0;
   int bad   = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick(); tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
      end
      start = 1'b1; a = 8'h12; b = 8'h34;
      tick();
      rst = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL start_with_rst: got busy=%b want 0", busy);
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL start_with_rst_after: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   // Full operation with exact cycle-by-cycle expectations; operands are zeroed
   // right after acceptance to prove they were captured on the accepting edge.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] esum, input logic ecout,
                         input logic [W-1:0] psum, input logic pcout, input string nm);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      tick();
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      for (int i = 0; i < W; i++) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s run_flags cyc%0d: got busy=%b done=%b want 1 0", nm, i, busy, done);
         end
         total++;
         if (sum !== psum || cout !== pcout) begin
            bad++;
            $display("FAIL %s hold cyc%0d: got sum=%h cout=%b want %h %b", nm, i, sum, cout, psum, pcout);
         end
         tick();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s done_pulse: got done=%b busy=%b want 1 0", nm, done, busy);
      end
      total++;
      if (sum !== esum || cout !== ecout) begin
         bad++;
         $display("FAIL %s result: got sum=%h cout=%b want %h %b", nm, sum, cout, esum, ecout);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== esum) begin
         bad++;
         $display("FAIL %s idle_after: got done=%b busy=%b sum=%h want 0 0 %h", nm, done, busy, sum, esum);
      end
   endtask

   task automatic test_basic();
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, "ff_plus_01");
      run_op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 8'h00, 1'b1, "3c_plus_0f_c1");
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      logic [W-1:0] got_sum = '0;
      logic got_cout = 1'b0;
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; a = 8'h11; b = 8'h22;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            ndone++;
            got_sum = sum;
            got_cout = cout;
         end
         tick();
      end
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL ignore_start_pulses: got %0d done pulses want 1", ndone);
      end
      total++;
      if (got_sum !== 8'h46 || got_cout !== 1'b0) begin
         bad++;
         $display("FAIL ignore_start_result: got sum=%h cout=%b want 46 0", got_sum, got_cout);
      end
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      a = 8'h55; b = 8'h22; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
      end
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1 || busy === 1'b1) ndone++;
         tick();
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
      end
   endtask

   task automatic test_back_to_back();
      int last = -1;
      int ndone = 0;
      a = 8'hA5; b = 8'h5A; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 35; i++) begin
         tick();
         if (done === 1'b1) begin
            total++;
            if (sum !== 8'hFF || cout !== 1'b0 || busy !== 1'b0) begin
               bad++;
               $display("FAIL b2b_result: got sum=%h cout=%b busy=%b want ff 0 0", sum, cout, busy);
            end
            if (last >= 0) begin
               total++;
               if (i - last != W + 2) begin
                  bad++;
                  $display("FAIL b2b_spacing: got %0d cycles want %0d", i - last, W + 2);
               end
            end
            last = i;
            ndone++;
         end
      end
      total++;
      if (ndone < 3) begin
         bad++;
         $display("FAIL b2b_count: got %0d done pulses want >=3", ndone);
      end
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_operand_change();
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, "operand_change");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_operand_change();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
